// File: rtl/square_plotter_pkg.sv
// square_plotter_pkg: shared screen bounds, colours, FSM encoding and request layout
package square_plotter_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam int REQ_X_W = 8;
  localparam int REQ_Y_W = 7;
  localparam int REQ_C_W = 3;
  typedef enum logic {IDLE, DRAW} state_t;
  typedef struct packed {
    logic [REQ_X_W-1:0] x;
    logic [REQ_Y_W-1:0] y;
    logic [REQ_C_W-1:0] colour;
  } req_t;
endpackage

// File: rtl/plot_req_fifo.sv
// plot_req_fifo: synchronous request FIFO; pushes when full and pops when empty are ignored
module plot_req_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int A_W = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [A_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [A_W:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (A_W+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rp_q];
  // pointer and occupancy update
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wp_d    = do_push ? wp_q + A_W'(1) : wp_q;
    rp_d    = do_pop ? rp_q + A_W'(1) : rp_q;
    cnt_d   = cnt_q + (A_W+1)'(do_push) - (A_W+1)'(do_pop);
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage, no reset needed since occupancy guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/square_plotter.sv
// square_plotter: expands queued square requests into row-major pixel writes; SQUARE_PLOTTER_CLIP_EN masks off-screen pixels
module square_plotter
  import square_plotter_pkg::*;
#(
  parameter int SQ_SIZE    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic [X_W-1:0]      starting_x,
  input  logic [Y_W-1:0]      starting_y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                ready,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  localparam int D_W = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
  localparam int R_W = X_W + Y_W + COLOUR_W;
  localparam logic [D_W-1:0] D_MAX = D_W'(SQ_SIZE - 1);
  state_t state_q, state_d;
  logic [D_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [X_W-1:0] bx_q, bx_d;
  logic [Y_W-1:0] by_q, by_d;
  logic [COLOUR_W-1:0] bc_q, bc_d;
  logic overflow_q, overflow_d;
  logic [R_W-1:0] head;
  logic full, empty, last, load, draw, in_bounds;
  plot_req_fifo #(.W(R_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (plot),
    .pop   (load),
    .din   ({starting_x, starting_y, colour}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // scan sequencing; the last pixel reloads straight from the FIFO so squares abut
  always_comb begin
    last       = state_q == DRAW && dx_q == D_MAX && dy_q == D_MAX;
    load       = (state_q == IDLE || last) && !empty;
    state_d    = load ? DRAW : last ? IDLE : state_q;
    dx_d       = (state_q == DRAW && !load) ? dx_q + D_W'(1) : '0;
    dy_d       = load ? '0 : (state_q == DRAW && dx_q == D_MAX) ? dy_q + D_W'(1) : dy_q;
    {bx_d, by_d, bc_d} = load ? head : {bx_q, by_q, bc_q};
    overflow_d = overflow_q | (plot & full);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dx_q       <= '0;
      dy_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      bc_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      bc_q       <= bc_d;
      overflow_q <= overflow_d;
    end
  end
  assign draw       = state_q == DRAW;
  assign vga_x      = draw ? bx_q + X_W'(dx_q) : '0;
  assign vga_y      = draw ? by_q + Y_W'(dy_q) : '0;
  assign vga_colour = draw ? bc_q : '0;
`ifdef SQUARE_PLOTTER_CLIP_EN
  assign in_bounds  = 32'(vga_x) < SCREEN_W && 32'(vga_y) < SCREEN_H;
`else
  assign in_bounds  = 1'b1;
`endif
  assign vga_plot   = draw & in_bounds;
  assign busy       = draw;
  assign done       = last;
  assign ready      = ~full;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_square_plotter.sv
// tb_square_plotter: directed checks of square_plotter against a per-cycle pixel timeline
module tb_square_plotter;
  import square_plotter_pkg::*;
  logic clk = 0, reset = 1, plot = 0;
  logic [7:0] starting_x = 0;
  logic [6:0] starting_y = 0;
  logic [2:0] colour = 0;
  logic ready, vga_plot, busy, done, overflow;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic d4_ready, d4_plot, d4_busy, d4_done, d4_overflow;
  logic [7:0] d4_x;
  logic [6:0] d4_y;
  logic [2:0] d4_colour;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       d;
  } pix_t;
  pix_t exp_q[$];
  int cyc = 0, n_vec = 0, n_err = 0, start_cyc = -1000, d4_cnt = 0, d4_base = 0, t0 = 0;
  bit mon_en = 0;

  square_plotter u_dut (
    .clk(clk), .reset(reset), .plot(plot), .starting_x(starting_x), .starting_y(starting_y),
    .colour(colour), .ready(ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done), .overflow(overflow)
  );

  square_plotter #(.FIFO_DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .plot(plot), .starting_x(starting_x), .starting_y(starting_y),
    .colour(colour), .ready(d4_ready), .vga_x(d4_x), .vga_y(d4_y), .vga_colour(d4_colour),
    .vga_plot(d4_plot), .busy(d4_busy), .done(d4_done), .overflow(d4_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (d4_plot === 1'b1) d4_cnt <= d4_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_sq(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        pix_t p;
        p.x = x + 8'(dx);
        p.y = y + 7'(dy);
        p.c = c;
`ifdef SQUARE_PLOTTER_CLIP_EN
        p.p = (32'(p.x) < SCREEN_W) && (32'(p.y) < SCREEN_H);
`else
        p.p = 1'b1;
`endif
        p.d = (dx == 3 && dy == 3);
        exp_q.push_back(p);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    plot = 1; starting_x = x; starting_y = y; colour = c;
    tick();
    plot = 0;
  endtask

  task automatic new_test();
    exp_q.delete();
    t0 = cyc;
    start_cyc = cyc + 2;
  endtask

  always @(negedge clk) begin : mon
    int k;
    if (mon_en) begin
      k = cyc - start_cyc;
      if (k >= 0 && k < exp_q.size()) begin
        check("pix_x", 32'(vga_x), 32'(exp_q[k].x));
        check("pix_y", 32'(vga_y), 32'(exp_q[k].y));
        check("pix_colour", 32'(vga_colour), 32'(exp_q[k].c));
        check("pix_plot", 32'(vga_plot), 32'(exp_q[k].p));
        check("pix_done", 32'(done), 32'(exp_q[k].d));
        check("pix_busy", 32'(busy), 32'd1);
      end else begin
        check("idle_plot", 32'(vga_plot), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) tick();
    reset = 0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    check("rst_y", 32'(vga_y), 32'd0);
    check("rst_colour", 32'(vga_colour), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    mon_en = 1;
    // single red square
    new_test();
    add_sq(8'd10, 7'd112, RED);
    send(8'd10, 7'd112, RED);
    repeat (25) tick();
    // burst of ten back-to-back squares
    new_test();
    for (int i = 0; i < 10; i++) add_sq(8'(10 * (i + 1)), 7'd112, (i % 2) ? YELLOW : RED);
    for (int i = 0; i < 10; i++) send(8'(10 * (i + 1)), 7'd112, (i % 2) ? YELLOW : RED);
    repeat (165) tick();
    check("burst_overflow", 32'(overflow), 32'd0);
    // overflow on the depth-4 instance
    reset = 1;
    tick();
    reset = 0;
    d4_base = d4_cnt;
    new_test();
    for (int i = 0; i < 6; i++) add_sq(8'(10 * i), 7'd20, GREEN);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("d4_ready_c4", 32'(d4_ready), 32'd1);
      if (i == 5) check("d4_ready_c5", 32'(d4_ready), 32'd0);
      send(8'(10 * i), 7'd20, GREEN);
    end
    repeat (110) tick();
    check("d4_overflow", 32'(d4_overflow), 32'd1);
    check("d4_pixels", 32'(d4_cnt - d4_base), 32'd80);
    check("main_no_overflow", 32'(overflow), 32'd0);
    // coordinate wrap
    new_test();
    add_sq(8'd254, 7'd126, BLUE);
    send(8'd254, 7'd126, BLUE);
    repeat (25) tick();
    // screen edge, clipped when the macro is defined; black is drawn like any colour
    new_test();
    add_sq(8'd158, 7'd118, BLACK);
    send(8'd158, 7'd118, BLACK);
    repeat (25) tick();
    // reset during the 7th pixel with three squares queued
    check("d4_overflow_pre", 32'(d4_overflow), 32'd1);
    new_test();
    for (int i = 0; i < 4; i++) add_sq(8'(20 * i), 7'd40, YELLOW);
    for (int i = 0; i < 4; i++) send(8'(20 * i), 7'd40, YELLOW);
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    check("rmid_plot", 32'(vga_plot), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ready", 32'(ready), 32'd1);
    check("rmid_overflow", 32'(overflow), 32'd0);
    check("rmid_d4_overflow", 32'(d4_overflow), 32'd0);
    repeat (30) tick();
    check("rmid_d4_idle", 32'(d4_busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/square_plotter.md
Name: square_plotter

Overview:
- Receive end of the square-draw request interface: consumes {plot, starting_x, starting_y, colour} requests from the square sequencer.
- Expands each request into S×S per-pixel writes {vga_x, vga_y, vga_colour, vga_plot} for the VGA adapter.
- A small request FIFO absorbs bursts, because the sequencer issues one request per clock and ignores backpressure.

Parameters:
- SQ_SIZE, 4, square side in pixels (power of 2, 2..8)
- FIFO_DEPTH, 16, request queue entries (power of 2, ≥4)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- plot  in  1  request valid; sampled every cycle
- starting_x  in  X_W  square top-left x
- starting_y  in  Y_W  square top-left y
- colour  in  COLOUR_W  square colour (000 = erase)
- ready  out  1  FIFO not full
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  pixel write enable
- busy  out  1  state == DRAW
- done  out  1  one-cycle pulse on the last pixel of each square
- overflow  out  1  sticky: a request was dropped

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values:
  - ready=1; all other outputs 0.
  - FIFO emptied; state IDLE; dx=dy=0.
- Push rule:
  - plot=1 and FIFO not full: {x,y,colour} written at the clock edge.
  - plot=1 and FIFO full: request dropped, overflow<=1, even if a pop occurs in the same cycle.
  - overflow cleared only by reset.
- States: IDLE, DRAW.
- IDLE:
  - FIFO non-empty: pop head; latch base_x/base_y/base_colour; dx=dy=0; go DRAW.
  - FIFO empty: stay IDLE.
- DRAW, outputs:
  - vga_plot=1.
  - vga_x=base_x+dx, vga_y=base_y+dy, vga_colour=base_colour.
- DRAW, scan order and exit:
  - Row-major: dx increments each cycle; at dx=SQ_SIZE-1, dx<=0 and dy++.
  - Last pixel (dx=dy=SQ_SIZE-1): done=1.
  - If FIFO non-empty on the last pixel: pop and reload, stay DRAW. Back-to-back squares have zero bubble cycles.
  - Otherwise go IDLE.
- Latency: a request sampled at edge t (idle, FIFO empty) produces its first pixel in cycle t+2. Each square takes exactly SQ_SIZE² cycles.
- Arithmetic: coordinate sums truncate to X_W/Y_W bits, so they wrap modulo 2^X_W / 2^Y_W. No saturation.
- Colour 000 is drawn like any other colour. The erase pass is simply a black square.
- Ordering: squares are drawn strictly in acceptance order.
- Reset mid-draw: vga_plot=0 the following cycle; queued requests discarded.

Optional Feature:
- Macro: SQUARE_PLOTTER_CLIP_EN.
- Defined: vga_plot is forced 0 for pixels with vga_x≥160 or vga_y≥120 (screen bounds from package). Cycle count, done and busy are unchanged; clipped pixels still occupy their cycle.
- Undefined: every pixel is plotted, with wrap-around coordinates.

Decomposition:
- Shared package holds:
  - SCREEN_W=160, SCREEN_H=120
  - colour constants BLACK=000, RED=100, YELLOW=110, GREEN=010, BLUE=001
  - state encoding IDLE/DRAW
  - request struct/field widths {x,y,colour}
- One sub-module: plot_req_fifo.
  - Synchronous FIFO: width X_W+Y_W+COLOUR_W, depth FIFO_DEPTH.
  - Ports: push/pop/full/empty.
  - Overflow detection stays in square_plotter.

Test Plan:
- Single request x=10, y=112, RED, SQ_SIZE=4:
  - 16 vga_plot cycles starting at t+2.
  - Order (10,112),(11,112)…(13,115), all colour 100.
  - done only on (13,115); busy high for exactly 16 cycles.
- Burst of 10 consecutive-cycle requests x=10,20…100, y=112, alternating RED/YELLOW:
  - 160 contiguous vga_plot cycles with no gaps and order preserved.
  - 10 done pulses; overflow stays 0.
- FIFO_DEPTH=4, 6 requests on consecutive cycles from idle:
  - First 5 accepted; the 6th (cycle 5, FIFO full) dropped.
  - overflow=1; 80 pixels drawn.
  - ready=0 during cycle 5.
- Wrap with macro undefined, x=254, y=126:
  - vga_x sequence 254,255,0,1 per row.
  - vga_y sequence 126,127,0,1.
- Macro defined, x=158, y=118:
  - 16 cycles total, vga_plot=1 only for x∈{158,159} × y∈{118,119} (4 pulses).
  - done on the 16th cycle.
- Reset asserted on the 7th pixel with 3 requests queued:
  - Next cycle: vga_plot=0, busy=0, ready=1, overflow=0.
  - No further pixels until a new request.
